// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter: start, DATA_WIDTH data bits (LSB first), optional parity, 1/2 stop bits.
// Define UART_TX_FIFO_EN to replace the single holding register with a FIFO_DEPTH-entry FIFO.
module uart_tx_param #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int PRESC_W    = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  output logic                  DATA_READY,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  input  logic [PRESC_W-1:0]    PRESCALE,
  output logic                  TX_OUT,
  output logic                  Busy
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH - 1);

  if (DATA_WIDTH < 5 || DATA_WIDTH > 9 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("uart_tx_param: unsupported DATA_WIDTH or FIFO_DEPTH");
  end

  state_t                state, next_state;
  logic [PRESC_W-1:0]    cnt;
  logic [PRESC_W-1:0]    presc_l;
  logic [3:0]            bit_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  par_bit;
  logic                  par_en_l;
  logic                  stop2_l;
  logic                  ready_en;
  logic                  buf_nempty;
  logic                  buf_full;
  logic [DATA_WIDTH-1:0] buf_data;
  logic                  push;
  logic                  pop;
  logic                  bit_end;
  logic                  last_data;
  logic                  last_stop;
  logic                  start_entry;
  logic                  tx_p1;
  logic                  busy_p1;

  // PRESCALE of 0 and 1 both give a one-cycle bit period.
  function automatic logic [PRESC_W-1:0] reload_val(input logic [PRESC_W-1:0] p);
    return (p == '0) ? '0 : p - PRESC_W'(1);
  endfunction

  assign DATA_READY = ready_en & ~buf_full;
  assign push       = DATA_VALID & DATA_READY;
  assign pop        = start_entry;

`ifdef UART_TX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [AW:0] FULL_LVL = LW'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           level;

  assign buf_full   = (level == FULL_LVL);
  assign buf_nempty = (level != '0);
  assign buf_data   = mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= P_DATA;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end
`else
  logic [DATA_WIDTH-1:0] hold_data;
  logic                  hold_vld;

  assign buf_full   = hold_vld;
  assign buf_nempty = hold_vld;
  assign buf_data   = hold_data;

  always_ff @(posedge CLK) begin
    if (push) hold_data <= P_DATA;
  end

  // Freed on the START pop so the next word can wait out the current frame.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)      hold_vld <= 1'b0;
    else if (push) hold_vld <= 1'b1;
    else if (pop)  hold_vld <= 1'b0;
  end
`endif

  assign bit_end     = (cnt == '0);
  assign last_data   = (bit_cnt == LAST_BIT);
  assign last_stop   = stop2_l ? (bit_cnt == 4'd1) : 1'b1;
  assign start_entry = (next_state == START) && (state != START);

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (buf_nempty) next_state = START;
      START:   if (bit_end) next_state = DATA;
      DATA:    if (bit_end && last_data) next_state = par_en_l ? PARITY : STOP;
      PARITY:  if (bit_end) next_state = STOP;
      STOP:    if (bit_end && last_stop) next_state = buf_nempty ? START : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // stage p0: FSM, bit-period timing and per-frame configuration
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_cnt  <= '0;
      presc_l  <= '0;
      par_en_l <= 1'b0;
      stop2_l  <= 1'b0;
      ready_en <= 1'b0;
    end else begin
      state    <= next_state;
      ready_en <= 1'b1;
      if (start_entry) begin
        cnt      <= reload_val(PRESCALE);
        presc_l  <= PRESCALE;
        par_en_l <= PAR_EN;
        stop2_l  <= STOP2;
      end else if (state == IDLE) begin
        cnt <= '0;
      end else if (bit_end) begin
        cnt <= reload_val(presc_l);
      end else begin
        cnt <= cnt - PRESC_W'(1);
      end
      if (next_state != state)
        bit_cnt <= '0;
      else if (bit_end && (state == DATA || state == STOP))
        bit_cnt <= bit_cnt + 4'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (start_entry) begin
      shreg   <= buf_data;
      par_bit <= (^buf_data) ^ PAR_TYP;
    end else if (state == DATA && bit_end) begin
      shreg <= shreg >> 1;
    end
  end

  // stage p1: registered line and busy, aligned with each other
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      tx_p1   <= 1'b1;
      busy_p1 <= 1'b0;
    end else begin
      busy_p1 <= (state != IDLE);
      case (state)
        START:   tx_p1 <= 1'b0;
        DATA:    tx_p1 <= shreg[0];
        PARITY:  tx_p1 <= par_bit;
        default: tx_p1 <= 1'b1;
      endcase
    end
  end

  assign TX_OUT = tx_p1;
  assign Busy   = busy_p1;

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: table-driven frames plus reset, back-to-back and width-5 sequences.
module tb_uart_tx_param;

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  P_DATA;
  logic        DATA_VALID;
  logic        DATA_READY;
  logic        PAR_EN;
  logic        PAR_TYP;
  logic        STOP2;
  logic [15:0] PRESCALE;
  logic        TX_OUT;
  logic        Busy;

  logic [4:0]  p_data5;
  logic        data_valid5;
  logic        data_ready5;
  logic        tx_out5;
  logic        busy5;

  always #5 CLK = ~CLK;

  uart_tx_param #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .PRESC_W(16)) u_dut (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID), .DATA_READY(DATA_READY),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2), .PRESCALE(PRESCALE),
    .TX_OUT(TX_OUT), .Busy(Busy)
  );

  uart_tx_param #(.DATA_WIDTH(5), .FIFO_DEPTH(4), .PRESC_W(16)) u_dut5 (
    .CLK(CLK), .RST(RST), .P_DATA(p_data5), .DATA_VALID(data_valid5), .DATA_READY(data_ready5),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2), .PRESCALE(PRESCALE),
    .TX_OUT(tx_out5), .Busy(busy5)
  );

  typedef struct {
    logic [7:0]  data;
    logic        par_en;
    logic        par_typ;
    logic        stop2;
    logic [15:0] presc;
    logic [63:0] exp_bits;  // line bit i of the frame at index i
    int          len;
    int          ppb;
  } vec_t;

  vec_t vecs[6];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive a word, check acceptance and the 2-cycle start latency, then scramble the
  // configuration inputs once the frame has latched them. Returns on the first start-bit cycle.
  task automatic launch(input vec_t v, input string name);
    @(posedge CLK); #1;
    P_DATA = v.data; PAR_EN = v.par_en; PAR_TYP = v.par_typ;
    STOP2 = v.stop2; PRESCALE = v.presc; DATA_VALID = 1'b1;
    check({name, " ready"}, 64'(DATA_READY), 64'd1);
    @(posedge CLK); #1;
    DATA_VALID = 1'b0;
    check({name, " tx at accept"}, 64'(TX_OUT), 64'd1);
    @(posedge CLK); #1;
    check({name, " tx latency"}, 64'(TX_OUT), 64'd1);
    check({name, " busy latency"}, 64'(Busy), 64'd0);
    PAR_EN = ~v.par_en; PAR_TYP = ~v.par_typ; STOP2 = ~v.stop2; PRESCALE = v.presc + 16'd3;
    @(posedge CLK); #1;
  endtask

  // Called on the first start-bit cycle; samples len*ppb cycles then checks the line is idle.
  task automatic expect_frame(input logic [63:0] bits, input int len, input int ppb,
                              input bit w5, input string name);
    logic [63:0] seen = '0;
    int unstable = 0;
    int busy_low = 0;
    logic tx, bz;
    for (int k = 0; k < len * ppb; k++) begin
      if (k > 0) begin
        @(posedge CLK); #1;
      end
      tx = w5 ? tx_out5 : TX_OUT;
      bz = w5 ? busy5 : Busy;
      if (k % ppb == 0) seen[k / ppb] = tx;
      else if (tx !== seen[k / ppb]) unstable++;
      if (bz !== 1'b1) busy_low++;
    end
    check({name, " bits"}, seen, bits);
    check({name, " bit period"}, 64'(unstable), 64'd0);
    check({name, " busy in frame"}, 64'(busy_low), 64'd0);
    @(posedge CLK); #1;
    check({name, " tx idle after"}, 64'(w5 ? tx_out5 : TX_OUT), 64'd1);
    check({name, " busy after"}, 64'(w5 ? busy5 : Busy), 64'd0);
  endtask

  initial begin
    logic [63:0] b2b;
    vec_t rv;
    int quiet;

    vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 16'd4, 64'b1101001010,   10, 4};
    vecs[1] = '{8'h07, 1'b1, 1'b0, 1'b0, 16'd1, 64'b11000001110,  11, 1};
    vecs[2] = '{8'h07, 1'b1, 1'b1, 1'b0, 16'd1, 64'b10000001110,  11, 1};
    vecs[3] = '{8'h00, 1'b0, 1'b0, 1'b1, 16'd2, 64'b11000000000,  11, 2};
    vecs[4] = '{8'hFF, 1'b1, 1'b0, 1'b0, 16'd0, 64'b10111111110,  11, 1};
    vecs[5] = '{8'h3C, 1'b1, 1'b1, 1'b1, 16'd3, 64'b111001111000, 12, 3};

    RST = 1'b0; P_DATA = '0; DATA_VALID = 1'b0; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    STOP2 = 1'b0; PRESCALE = 16'd1; p_data5 = '0; data_valid5 = 1'b0;

    repeat (3) @(posedge CLK);
    #1;
    check("reset tx", 64'(TX_OUT), 64'd1);
    check("reset busy", 64'(Busy), 64'd0);
    check("reset ready", 64'(DATA_READY), 64'd0);
    check("reset ready w5", 64'(data_ready5), 64'd0);
    RST = 1'b1;
    #1;
    check("ready before first edge", 64'(DATA_READY), 64'd0);
    @(posedge CLK); #1;
    check("ready after first edge", 64'(DATA_READY), 64'd1);

    for (int i = 0; i < 5; i++) begin
      launch(vecs[i], $sformatf("vec%0d", i));
      expect_frame(vecs[i].exp_bits, vecs[i].len, vecs[i].ppb, 1'b0, $sformatf("vec%0d", i));
    end

    // Back-to-back: 0x5A then 0xC3 at PRESCALE=2 with no gap between frames.
    b2b = {44'd0, 10'b1110000110, 10'b1010110100};
    @(posedge CLK); #1;
    PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0; PRESCALE = 16'd2;
    P_DATA = 8'h5A; DATA_VALID = 1'b1;
    @(posedge CLK); #1;
    P_DATA = 8'hC3;
`ifndef UART_TX_FIFO_EN
    check("b2b holding full", 64'(DATA_READY), 64'd0);
    @(posedge CLK); #1;
    check("b2b holding freed", 64'(DATA_READY), 64'd1);
    @(posedge CLK); #1;
    DATA_VALID = 1'b0;
    check("b2b holding refilled", 64'(DATA_READY), 64'd0);
`else
    @(posedge CLK); #1;
    DATA_VALID = 1'b0;
    @(posedge CLK); #1;
`endif
    expect_frame(b2b, 20, 2, 1'b0, "b2b");

    // Reset during the third data bit of a 0x00 frame, then a clean 0x3C frame.
    rv = '{8'h00, 1'b0, 1'b0, 1'b0, 16'd4, 64'd0, 10, 4};
    launch(rv, "rstmid");
    repeat (13) @(posedge CLK);
    #1;
    check("rstmid tx in data", 64'(TX_OUT), 64'd0);
    check("rstmid busy in data", 64'(Busy), 64'd1);
    #2 RST = 1'b0;
    #1;
    check("rstmid tx async", 64'(TX_OUT), 64'd1);
    check("rstmid busy async", 64'(Busy), 64'd0);
    check("rstmid ready", 64'(DATA_READY), 64'd0);
    repeat (3) @(posedge CLK);
    #1 RST = 1'b1;
    quiet = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge CLK); #1;
      if (TX_OUT !== 1'b1 || Busy !== 1'b0) quiet++;
    end
    check("rstmid no resume", 64'(quiet), 64'd0);
    launch(vecs[5], "vec5");
    expect_frame(vecs[5].exp_bits, vecs[5].len, vecs[5].ppb, 1'b0, "vec5");

    // 5-bit instance, PRESCALE=0: one cycle per bit.
    @(posedge CLK); #1;
    PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP2 = 1'b0; PRESCALE = 16'd0;
    p_data5 = 5'h1F; data_valid5 = 1'b1;
    check("w5 ready", 64'(data_ready5), 64'd1);
    @(posedge CLK); #1;
    data_valid5 = 1'b0;
    @(posedge CLK); #1;
    check("w5 tx latency", 64'(tx_out5), 64'd1);
    @(posedge CLK); #1;
    expect_frame(64'b1111110, 7, 1, 1'b1, "w5");

`ifdef UART_TX_FIFO_EN
    begin : fifo_test
      logic [7:0]  words[6];
      logic [63:0] fexp;
      int          idx;
      bit          saw_full;
      words = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16};
      fexp = '0;
      for (int i = 0; i < 6; i++) fexp |= {54'd0, 1'b1, words[i], 1'b0} << (10 * i);
      @(posedge CLK); #1;
      PAR_EN = 1'b0; STOP2 = 1'b0; PRESCALE = 16'd1;
      P_DATA = words[0]; DATA_VALID = 1'b1;
      idx = 0; saw_full = 1'b0;
      fork
        begin
          for (int g = 0; g < 200 && idx < 6; g++) begin
            logic acc;
            acc = DATA_READY;
            if (!acc) saw_full = 1'b1;
            @(posedge CLK); #1;
            if (acc) begin
              idx++;
              if (idx < 6) P_DATA = words[idx];
            end
          end
          DATA_VALID = 1'b0;
        end
        begin
          repeat (3) @(posedge CLK);
          #1;
          expect_frame(fexp, 60, 1, 1'b0, "fifo");
        end
      join
      check("fifo words accepted", 64'(idx), 64'd6);
      check("fifo ready dropped", 64'(saw_full), 64'd1);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
